// File: rtl/add_sub_arb_pkg.sv
// Shared types and helpers for the add/sub arbiter slice.
package add_sub_arb_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_FULL
    } state_t;

    localparam int DEF_DATA_WD = 4;
    localparam int DEF_NUM_REQ = 4;

    // Explicit wrap so non-power-of-two requester counts work.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/prog_add_sub.sv
// Unsigned add/subtract datapath; add yields carry in the MSB, subtract flags borrow.
module prog_add_sub #(
    parameter int WD = 4
) (
    input  logic [WD-1:0] a,
    input  logic [WD-1:0] b,
    input  logic          mode,
    output logic [WD:0]   result,
    output logic          ovr
);

    logic [WD:0] sum;
    logic [WD:0] diff;

    always_comb begin
        sum  = {1'b0, a} + {1'b0, b};
        diff = {1'b0, a} - {1'b0, b};
        if (mode) begin
            result = {1'b0, diff[WD-1:0]};
            ovr    = diff[WD];
        end else begin
            result = sum;
            ovr    = 1'b0;
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr, with wrap-around.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    input  logic                 en,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 any_grant
);

    localparam int PTR_WD = $clog2(N);
    localparam logic [PTR_WD:0] N_W = (PTR_WD + 1)'(N);

    logic [PTR_WD:0] idx;
    logic            found;

    always_comb begin
        idx       = '0;
        found     = 1'b0;
        grant_idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = {1'b0, ptr} + (PTR_WD + 1)'(i);
            if (idx >= N_W) begin
                idx = idx - N_W;
            end
            if (!found && req[idx[PTR_WD-1:0]]) begin
                found     = 1'b1;
                grant_idx = idx[PTR_WD-1:0];
            end
        end
        any_grant = found & en;
        grant     = '0;
        if (any_grant) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/add_sub_arbiter.sv
// Round-robin sharing of one prog_add_sub among NUM_REQ requesters, single-entry response slot.
// Define ADD_SUB_ARB_SAT_EN for saturating results (ovr flag unchanged).
module add_sub_arbiter
    import add_sub_arb_pkg::*;
#(
    parameter int DATA_WD = DEF_DATA_WD,
    parameter int NUM_REQ = DEF_NUM_REQ
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [NUM_REQ-1:0]           i_req_valid,
    output logic [NUM_REQ-1:0]           o_req_ready,
    input  logic [NUM_REQ*DATA_WD-1:0]   i_req_a,
    input  logic [NUM_REQ*DATA_WD-1:0]   i_req_b,
    input  logic [NUM_REQ-1:0]           i_req_mode,
    output logic                         o_rsp_valid,
    input  logic                         i_rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]   o_rsp_id,
    output logic [DATA_WD:0]             o_rsp_result,
    output logic                         o_rsp_ovr
);

    localparam int ID_WD = $clog2(NUM_REQ);

    state_t             state;
    state_t             state_nxt;
    logic [ID_WD-1:0]   ptr;
    logic               slot_free;
    logic [NUM_REQ-1:0] grant;
    logic [ID_WD-1:0]   grant_idx;
    logic               accept;
    logic [DATA_WD-1:0] a_arr [NUM_REQ];
    logic [DATA_WD-1:0] b_arr [NUM_REQ];
    logic [DATA_WD-1:0] op_a;
    logic [DATA_WD-1:0] op_b;
    logic               op_mode;
    logic [DATA_WD:0]   raw_result;
    logic               raw_ovr;
    logic [DATA_WD:0]   fin_result;

    // Draining and refilling in the same cycle keeps one result per cycle.
    assign slot_free = (state == ST_IDLE) | i_rsp_ready;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .req       (i_req_valid),
        .ptr       (ptr),
        .en        (slot_free & ~i_rst),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (accept)
    );

    assign o_req_ready = grant;

    always_comb begin
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            a_arr[k] = i_req_a[k*DATA_WD +: DATA_WD];
            b_arr[k] = i_req_b[k*DATA_WD +: DATA_WD];
        end
    end

    assign op_a    = a_arr[grant_idx];
    assign op_b    = b_arr[grant_idx];
    assign op_mode = i_req_mode[grant_idx];

    prog_add_sub #(
        .WD (DATA_WD)
    ) u_add_sub (
        .a      (op_a),
        .b      (op_b),
        .mode   (op_mode),
        .result (raw_result),
        .ovr    (raw_ovr)
    );

`ifdef ADD_SUB_ARB_SAT_EN
    always_comb begin
        fin_result = raw_result;
        if (!op_mode && raw_result[DATA_WD]) begin
            fin_result = {1'b0, {DATA_WD{1'b1}}};
        end else if (op_mode && raw_ovr) begin
            fin_result = '0;
        end
    end
`else
    assign fin_result = raw_result;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_FULL;
            ST_FULL: begin
                if (accept) begin
                    state_nxt = ST_FULL;
                end else if (i_rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= ST_IDLE;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                ptr <= ID_WD'(rr_next(32'(grant_idx), NUM_REQ));
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_rsp_id     <= '0;
            o_rsp_result <= '0;
            o_rsp_ovr    <= 1'b0;
        end else if (accept) begin
            o_rsp_id     <= grant_idx;
            o_rsp_result <= fin_result;
            o_rsp_ovr    <= raw_ovr;
        end
    end

    assign o_rsp_valid = (state == ST_FULL);

endmodule

// File: tb/tb_add_sub_arbiter.sv
// Randomized bench for add_sub_arbiter against a behavioural slot/round-robin model.
module tb_add_sub_arbiter;

    localparam int DW = 4;
    localparam int NR = 4;

    logic          clk;
    logic          rst;
    logic [NR-1:0] req_valid;
    logic [NR-1:0] req_ready;
    logic [NR*DW-1:0] req_a;
    logic [NR*DW-1:0] req_b;
    logic [NR-1:0] req_mode;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [1:0]    rsp_id;
    logic [DW:0]   rsp_result;
    logic          rsp_ovr;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int m_ptr;
    bit m_full;
    int m_id;
    int m_res;
    int m_ovr;

    add_sub_arbiter #(
        .DATA_WD (DW),
        .NUM_REQ (NR)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_a      (req_a),
        .i_req_b      (req_b),
        .i_req_mode   (req_mode),
        .o_rsp_valid  (rsp_valid),
        .i_rsp_ready  (rsp_ready),
        .o_rsp_id     (rsp_id),
        .o_rsp_result (rsp_result),
        .o_rsp_ovr    (rsp_ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void ref_op(input int a, input int b, input bit sub, output int res, output int ovr);
        if (!sub) begin
            ovr = 0;
            res = (a + b) % 32;
`ifdef ADD_SUB_ARB_SAT_EN
            if (a + b > 15) res = 15;
`endif
        end else begin
            ovr = (a < b) ? 1 : 0;
            res = (a - b + 16) % 16;
`ifdef ADD_SUB_ARB_SAT_EN
            if (a < b) res = 0;
`endif
        end
    endfunction

    function automatic int ref_grant(input logic [NR-1:0] v);
        for (int i = 0; i < NR; i++) begin
            if (v[(m_ptr + i) % NR]) return (m_ptr + i) % NR;
        end
        return -1;
    endfunction

    // Called away from the clock edge; checks this cycle, then advances the model at the edge.
    task automatic do_cycle(input logic [NR-1:0] v, input logic [NR*DW-1:0] a,
                            input logic [NR*DW-1:0] b, input logic [NR-1:0] m, input logic rr);
        int g;
        int exp_ready;
        bit free;
        int na, nb, res, ovr;
        req_valid = v;
        req_a     = a;
        req_b     = b;
        req_mode  = m;
        rsp_ready = rr;
        @(negedge clk);
        check("rsp_valid", 32'(rsp_valid), 32'(m_full));
        if (m_full) begin
            check("rsp_id", 32'(rsp_id), 32'(m_id));
            check("rsp_result", 32'(rsp_result), 32'(m_res));
            check("rsp_ovr", 32'(rsp_ovr), 32'(m_ovr));
        end
        free = !m_full || rr;
        g = ref_grant(v);
        exp_ready = (free && g >= 0) ? (1 << g) : 0;
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        @(posedge clk);
        #1;
        if (exp_ready != 0) begin
            na = int'(a[g*DW +: DW]);
            nb = int'(b[g*DW +: DW]);
            ref_op(na, nb, m[g], res, ovr);
            m_full = 1;
            m_id   = g;
            m_res  = res;
            m_ovr  = ovr;
            m_ptr  = (g + 1) % NR;
        end else if (rr) begin
            m_full = 0;
        end
    endtask

    task automatic do_reset(input bit async_chk);
        rst = 1'b1;
        #1;
        if (async_chk) begin
            check("rst_async_valid", 32'(rsp_valid), 32'd0);
            check("rst_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_id", 32'(rsp_id), 32'd0);
        check("rst_result", 32'(rsp_result), 32'd0);
        check("rst_ovr", 32'(rsp_ovr), 32'd0);
        check("rst_ready_hold", 32'(req_ready), 32'd0);
        rst    = 1'b0;
        m_ptr  = 0;
        m_full = 0;
        m_id   = 0;
        m_res  = 0;
        m_ovr  = 0;
    endtask

    initial begin
        logic [NR*DW-1:0] ra, rb;
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_mode  = '0;
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        do_reset(1'b0);

        // req0 add 9+8
        do_cycle(4'b0001, 16'h0009, 16'h0008, 4'b0000, 1'b1);
`ifdef ADD_SUB_ARB_SAT_EN
        check("add98_result", 32'(rsp_result), 32'b01111);
`else
        check("add98_result", 32'(rsp_result), 32'b10001);
`endif
        check("add98_id", 32'(rsp_id), 32'd0);

        // req2 sub 3-5
        do_cycle(4'b0100, 16'h0300, 16'h0500, 4'b0100, 1'b1);
`ifdef ADD_SUB_ARB_SAT_EN
        check("sub35_result", 32'(rsp_result), 32'b00000);
`else
        check("sub35_result", 32'(rsp_result), 32'b01110);
`endif
        check("sub35_ovr", 32'(rsp_ovr), 32'd1);
        check("sub35_id", 32'(rsp_id), 32'd2);

        // all valid streaming from pointer 0
        do_reset(1'b0);
        for (int i = 0; i < 8; i++) begin
            do_cycle(4'b1111, 16'h4321 + 16'(i), 16'h1234, 4'b1010, 1'b1);
            check("stream_id", 32'(rsp_id), 32'(i % NR));
        end

        // pointer 1, only req0/req3 valid -> 3 then 0
        do_reset(1'b0);
        do_cycle(4'b0001, 16'h0001, 16'h0001, 4'b0000, 1'b1);
        do_cycle(4'b1001, 16'h7001, 16'h2001, 4'b1000, 1'b1);
        check("ptr1_first", 32'(rsp_id), 32'd3);
        do_cycle(4'b1001, 16'h7001, 16'h2001, 4'b1000, 1'b1);
        check("ptr1_second", 32'(rsp_id), 32'd0);

        // stall three cycles, then drain and refill together
        for (int i = 0; i < 3; i++) do_cycle(4'b1111, 16'hFFFF, 16'h0001, 4'b0000, 1'b0);
        do_cycle(4'b1111, 16'hFFFF, 16'h0001, 4'b0000, 1'b1);
        check("refill_id", 32'(rsp_id), 32'd1);

        // reset while the slot is full
        do_cycle(4'b0010, 16'h0050, 16'h0030, 4'b0000, 1'b0);
        req_valid = 4'b1111;
        do_reset(1'b1);
        do_cycle(4'b1111, 16'h1111, 16'h1111, 4'b0000, 1'b1);
        check("post_rst_id", 32'(rsp_id), 32'd0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if ($urandom_range(0, 199) == 0) begin
                req_valid = 4'($urandom);
                do_reset(1'b1);
            end
            do_cycle(4'($urandom), ra, rb, 4'($urandom), ($urandom_range(0, 3) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
